// File: rtl/gray_count_reader.sv
// gray_count_reader: synchronizes a gray-coded event count that ticks in another
// clock domain, decodes it to binary and hands out {absolute count, increment
// since the previous report} one report at a time. Also keeps a sticky flag for
// synchronized samples that moved by more than one gray bit in a single cycle.
//
// Handshake: a report is offered while valid is high, and count_out/delta_out
// hold still until the consumer raises ready in the same cycle (valid & ready on
// a rising edge = accepted). ready is ignored while valid is low.
module gray_count_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] delta_out,
  output logic             sample_dropped,
  output logic             gray_err,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, gray_prev_q;
  logic             gray_err_q;
  logic [WIDTH-1:0] bin_w;
  logic [WIDTH-1:0] gray_diff_w;
  logic             multi_bit_w;
  logic             accept_w;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic [WIDTH-1:0] bin_prev_q, bin_prev_d;
  logic             pending_q, pending_d;
  logic             dropped_q, dropped_d;
  logic             req_extra;

  // Gray-to-binary decode of the synchronized value: each binary bit is the XOR
  // of the gray bits at and above it.
  always_comb begin
    bin_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_w[i] = ^(sync2_q >> i);
    end
  end

  // More than one bit set in the difference means the code skipped a step
  // (x & (x-1) clears the lowest set bit, so any remainder means two or more).
  assign gray_diff_w = sync2_q ^ gray_prev_q;
  assign multi_bit_w = (gray_diff_w & (gray_diff_w - WIDTH'(1))) != '0;
  assign accept_w    = valid_q & ready;

  // Two-flop synchronizer, one-cycle history of sync2 and the sticky integrity flag.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      gray_prev_q <= '0;
      gray_err_q  <= 1'b0;
    end else begin
      sync1_q     <= gray_in;
      sync2_q     <= sync1_q;
      gray_prev_q <= sync2_q;
      gray_err_q  <= gray_err_q | multi_bit_w;
    end
  end

  // Report FSM next state: capture, hold until accepted, remember one extra request.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    count_d    = count_q;
    delta_d    = delta_q;
    bin_prev_d = bin_prev_q;
    pending_d  = pending_q;
    dropped_d  = 1'b0;
    req_extra  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        count_d    = bin_w;
        delta_d    = bin_w - bin_prev_q;
        bin_prev_d = bin_w;
        valid_d    = 1'b1;
        state_d    = ST_HOLD;
        req_extra  = sample;
      end
      ST_HOLD: begin
        if (accept_w) begin
          valid_d = 1'b0;
          if (pending_q || sample) begin
            pending_d = 1'b0;
            state_d   = ST_CAPTURE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          req_extra = sample;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Only one request can wait behind the report in flight; a second is lost.
    if (req_extra) begin
      if (pending_q) dropped_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // Report FSM registers.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      count_q    <= '0;
      delta_q    <= '0;
      bin_prev_q <= '0;
      pending_q  <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      delta_q    <= delta_d;
      bin_prev_q <= bin_prev_d;
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
    end
  end

  assign valid          = valid_q;
  assign count_out      = count_q;
  assign delta_out      = delta_q;
  assign sample_dropped = dropped_q;
  assign gray_err       = gray_err_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_gray_count_reader.sv
// Bench for gray_count_reader: directed scenarios plus a random phase, checked
// against a count/handshake reference model and a report scoreboard.
module tb_gray_count_reader;

  localparam int W   = 8;
  localparam int MOD = 1 << W;
  localparam int PH_IDLE = 0;
  localparam int PH_CAP  = 1;
  localparam int PH_HOLD = 2;

  // ---------------- clock / reset / DUT ----------------
  logic         clk_master = 1'b0;
  logic         rstb = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         sample = 1'b0;
  logic         ready = 1'b0;
  logic         valid;
  logic [W-1:0] count_out;
  logic [W-1:0] delta_out;
  logic         sample_dropped;
  logic         gray_err;
  logic [1:0]   state_dbg_o;

  always #5 clk_master = ~clk_master;

  gray_count_reader #(.WIDTH(W)) dut (
    .clk_master     (clk_master),
    .rstb           (rstb),
    .gray_in        (gray_in),
    .sample         (sample),
    .ready          (ready),
    .valid          (valid),
    .count_out      (count_out),
    .delta_out      (delta_out),
    .sample_dropped (sample_dropped),
    .gray_err       (gray_err),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- scoreboard / model state ----------------
  logic [2*W-1:0] exp_q[$];      // {count, delta} of each report the model captured
  logic [W-1:0]   rep_cnt[$];    // accepted reports as seen by the monitor
  logic [W-1:0]   rep_dlt[$];
  logic [W-1:0]   gh[$];         // gray values present at recent edges (oldest first)
  int             inv_tab[MOD];  // gray code -> count
  int             m_phase = PH_IDLE;
  bit             m_valid = 0;
  bit             m_pending = 0;
  bit             m_dropped = 0;
  bit             m_err = 0;
  int             m_last = 0;
  int             n_chk = 0;
  int             n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gray_of(input int n);
    return W'((n % MOD) ^ ((n % MOD) >> 1));
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_valid = 0; m_pending = 0; m_dropped = 0; m_err = 0; m_last = 0;
    exp_q.delete();
    gh.delete();
    repeat (3) gh.push_back('0);
  endtask

  // One rising edge of the reference model. The value the reader sees at an edge
  // is the gray input that was present two edges earlier.
  task automatic model_edge(input bit s, input bit r, input logic [W-1:0] g);
    bit acc;
    bit req;
    int cap;
    logic [W-1:0] seen, seen_before;
    seen        = gh[gh.size()-2];
    seen_before = gh[gh.size()-3];
    acc = m_valid && r;
    req = 0;
    if ($countones(seen ^ seen_before) > 1) m_err = 1;
    case (m_phase)
      PH_IDLE: if (s) m_phase = PH_CAP;
      PH_CAP: begin
        cap = inv_tab[seen];
        exp_q.push_back({W'(cap), W'((cap - m_last + MOD) % MOD)});
        m_last  = cap;
        m_valid = 1;
        m_phase = PH_HOLD;
        req = s;
      end
      default: begin
        if (acc) begin
          m_valid = 0;
          if (m_pending || s) begin
            m_pending = 0;
            m_phase = PH_CAP;
          end else begin
            m_phase = PH_IDLE;
          end
        end else begin
          req = s;
        end
      end
    endcase
    m_dropped = req && m_pending;
    if (req && !m_pending) m_pending = 1;
    gh.push_back(g);
    if (gh.size() > 4) void'(gh.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit s, input bit r, input logic [W-1:0] g);
    sample = s; ready = r; gray_in = g;
    @(posedge clk_master);
    if (rstb) model_edge(s, r, g);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    model_reset();
    repeat (3) tick(0, 0, '0);
    rstb = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_master) begin
    chk("valid", valid, m_valid);
    chk("sample_dropped", sample_dropped, m_dropped);
    chk("gray_err", gray_err, m_err);
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        chk("count_out", count_out, exp_q[0][2*W-1:W]);
        chk("delta_out", delta_out, exp_q[0][W-1:0]);
        if (ready) begin
          void'(exp_q.pop_front());
          rep_cnt.push_back(count_out);
          rep_dlt.push_back(delta_out);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int sum;
    bit mono;
    for (int k = 0; k < MOD; k++) inv_tab[(k ^ (k >> 1)) % MOD] = k;
    model_reset();

    // Reset state and first report: delta equals count.
    do_reset();
    chk("reset_valid", valid, 0);
    chk("reset_count", count_out, 0);
    chk("reset_err", gray_err, 0);
    repeat (4) tick(0, 0, gray_of(5));
    tick(1, 0, gray_of(5));
    tick(0, 0, gray_of(5));
    chk("first_valid", valid, 1);
    chk("first_count", count_out, 5);
    chk("first_delta", delta_out, 5);
    tick(0, 1, gray_of(5));
    chk("first_accept_valid", valid, 0);

    // Slow gray stepping with periodic samples.
    do_reset();
    rep_cnt.delete(); rep_dlt.delete();
    for (int c = 0; c < 70; c++) tick((c % 7) == 0, 1, gray_of((c / 3 < 20) ? c / 3 : 20));
    repeat (5) tick(0, 1, gray_of(20));
    chk("step_reports", rep_cnt.size(), 10);
    mono = 1;
    sum = 0;
    for (int i = 0; i < rep_cnt.size(); i++) begin
      if (i > 0 && rep_cnt[i] < rep_cnt[i-1]) mono = 0;
      sum += rep_dlt[i];
    end
    chk("step_monotonic", mono, 1);
    chk("step_last_count", rep_cnt[rep_cnt.size()-1], 20);
    chk("step_delta_sum", sum % MOD, 20);
    chk("step_gray_err", gray_err, 0);

    // Wrap-around of the delta.
    for (n = 21; n <= 250; n++) tick(0, 1, gray_of(n));
    repeat (3) tick(0, 1, gray_of(250));
    tick(1, 1, gray_of(250));
    repeat (4) tick(0, 1, gray_of(250));
    chk("wrap_pre_count", rep_cnt[rep_cnt.size()-1], 250);
    for (n = 251; n <= 259; n++) tick(0, 1, gray_of(n));
    repeat (3) tick(0, 1, gray_of(3));
    tick(1, 1, gray_of(3));
    repeat (4) tick(0, 1, gray_of(3));
    chk("wrap_count", rep_cnt[rep_cnt.size()-1], 3);
    chk("wrap_delta", rep_dlt[rep_dlt.size()-1], 9);

    // Back-pressure: one pending request, one dropped.
    for (n = 4; n <= 40; n++) tick(0, 1, gray_of(n));
    repeat (3) tick(0, 1, gray_of(40));
    rep_cnt.delete(); rep_dlt.delete();
    tick(1, 0, gray_of(40));
    tick(0, 0, gray_of(40));
    chk("bp_first_valid", valid, 1);
    chk("bp_first_count", count_out, 40);
    tick(1, 0, gray_of(41));
    tick(0, 0, gray_of(41));
    chk("bp_no_drop_yet", sample_dropped, 0);
    tick(1, 0, gray_of(42));
    chk("bp_dropped_pulse", sample_dropped, 1);
    tick(0, 0, gray_of(42));
    chk("bp_dropped_clear", sample_dropped, 0);
    repeat (3) tick(0, 0, gray_of(42));
    chk("bp_hold_count", count_out, 40);
    tick(0, 1, gray_of(42));
    chk("bp_gap_valid", valid, 0);
    tick(0, 0, gray_of(42));
    chk("bp_second_valid", valid, 1);
    chk("bp_second_count", count_out, 42);
    chk("bp_second_delta", delta_out, 2);
    tick(0, 1, gray_of(42));
    repeat (4) tick(0, 1, gray_of(42));
    chk("bp_report_total", rep_cnt.size(), 2);

    // Random phase: counter advances one code at a time, random sample/ready.
    n = 42;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) n = (n + 1) % MOD;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, gray_of(n));
    end
    repeat (8) tick(0, 1, gray_of(n));
    chk("random_drained", exp_q.size(), 0);

    // Integrity violation, then reset during a held report.
    do_reset();
    repeat (4) tick(0, 1, '0);
    chk("jump_err_before", gray_err, 0);
    repeat (6) tick(0, 0, 8'h03);
    chk("jump_err_set", gray_err, 1);
    tick(1, 0, 8'h03);
    tick(0, 0, 8'h03);
    tick(0, 0, 8'h03);
    chk("jump_err_sticky", gray_err, 1);
    chk("jump_hold_valid", valid, 1);
    chk("jump_hold_count", count_out, 2);
    #3;
    rstb = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_count", count_out, 0);
    chk("async_rst_delta", delta_out, 0);
    chk("async_rst_dropped", sample_dropped, 0);
    chk("async_rst_err", gray_err, 0);
    repeat (2) tick(0, 0, 8'h03);
    rstb = 1'b1;
    repeat (5) tick(0, 1, 8'h03);
    chk("post_rst_no_valid", valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
